// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-wide memory bus master: request sizes,
// controller states and the IO window tag.
package mem_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [1:0] IO_TAG = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_e;

    // Number of bus beats for a request size; the illegal code 3 runs as a word.
    function automatic logic [2:0] num_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: num_bytes = 3'd1;
            SZ_HALF: num_bytes = 3'd2;
            default: num_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_ext.sv
// Size/sign extension of the little-endian assembled load value.
module mem_ctrl_ext
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  size_i,
    input  logic        sgn_i,
    output logic [31:0] data_o
);

    // Replicate the top valid bit (or zero) above the loaded width.
    always_comb begin
        data_o = data_i;
        case (size_i)
            SZ_BYTE: data_o = {{24{sgn_i & data_i[7]}}, data_i[7:0]};
            SZ_HALF: data_o = {{16{sgn_i & data_i[15]}}, data_i[15:0]};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Serialises byte/half/word load-store requests onto the byte-wide memory bus
// and returns a single extended response per request.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 17
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [31:0] wdata_q, wdata_d;
    logic        io_q, io_d;
    logic [2:0]  i_q, i_d;
    logic [2:0]  c_q, c_d;
    logic        pend_q, pend_d;
    logic [31:0] asm_q, asm_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic [2:0]  n_s;
    logic [31:0] asm_cap_s;
    logic [31:0] ext_s;
    logic        issue_s;

    assign n_s = num_bytes(size_q);

    // Assembly value as it would look with the byte on mem_din placed at slot c.
    always_comb begin
        asm_cap_s = asm_q;
        asm_cap_s[{c_q[1:0], 3'b000} +: 8] = mem_din;
    end

    mem_ctrl_ext u_ext (
        .data_i (asm_cap_s),
        .size_i (size_q),
        .sgn_i  (sgn_q),
        .data_o (ext_s)
    );

    // Next-state, counters and bus drive.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        sgn_d        = sgn_q;
        wdata_d      = wdata_q;
        io_d         = io_q;
        i_d          = i_q;
        c_d          = c_q;
        pend_d       = pend_q;
        asm_d        = asm_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'd0;
        issue_s      = 1'b0;
        req_ready    = 1'b0;
        mem_a        = 32'd0;
        mem_dout     = 8'd0;
        mem_wr       = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    size_d  = req_size;
                    sgn_d   = req_signed;
                    wdata_d = req_wdata;
                    io_d    = (req_addr[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1] == IO_TAG);
                    i_d     = 3'd0;
                    c_d     = 3'd0;
                    pend_d  = 1'b0;
                    asm_d   = 32'd0;
                    state_d = req_wr ? WR : RD;
                end else begin
                    state_d = IDLE;
                end
            end
            WR: begin
                mem_a    = addr_q + {29'd0, i_q};
                mem_dout = wdata_q[{i_q[1:0], 3'b000} +: 8];
                mem_wr   = rdy_in;
                if (rdy_in) begin
                    if (i_q == n_s - 3'd1) begin
                        state_d      = IDLE;
                        resp_valid_d = 1'b1;
                    end else begin
                        i_d = i_q + 3'd1;
                    end
                end else begin
                    i_d = i_q;
                end
            end
            RD: begin
                // IO reads keep the address of the byte in flight until it is captured.
                mem_a = addr_q + {29'd0, (io_q ? c_q : i_q)};
                if (!rdy_in) begin
                    i_d    = c_q;
                    pend_d = 1'b0;
                end else begin
                    issue_s = (i_q < n_s) && (!io_q || !pend_q);
                    if (pend_q) begin
                        asm_d = asm_cap_s;
                        c_d   = c_q + 3'd1;
                        if (c_q == n_s - 3'd1) begin
                            state_d      = IDLE;
                            resp_valid_d = 1'b1;
                            resp_rdata_d = ext_s;
                        end else begin
                            state_d = RD;
                        end
                    end else begin
                        c_d = c_q;
                    end
                    i_d    = issue_s ? (i_q + 3'd1) : i_q;
                    pend_d = issue_s;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= IDLE;
            addr_q       <= 32'd0;
            size_q       <= 2'd0;
            sgn_q        <= 1'b0;
            wdata_q      <= 32'd0;
            io_q         <= 1'b0;
            i_q          <= 3'd0;
            c_q          <= 3'd0;
            pend_q       <= 1'b0;
            asm_q        <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            sgn_q        <= sgn_d;
            wdata_q      <= wdata_d;
            io_q         <= io_d;
            i_q          <= i_d;
            c_q          <= c_d;
            pend_q       <= pend_d;
            asm_q        <= asm_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte-wide memory responder on the bus.
module tb_mem_ctrl;

    logic        clk_in;
    logic        rst_n_in;
    logic        rdy_in;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    int n_chk;
    int n_fail;

    logic [7:0] mem [logic [31:0]];

    mem_ctrl #(.RAM_ADDR_WIDTH(17)) dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .rdy_in     (rdy_in),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .mem_a      (mem_a),
        .mem_wr     (mem_wr)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Synchronous byte memory: writes commit and reads launch on a granted edge.
    always @(posedge clk_in) begin
        if (rdy_in) begin
            if (mem_wr) begin
                mem[mem_a] = mem_dout;
            end
            mem_din <= mem.exists(mem_a) ? mem[mem_a] : 8'h00;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rdy);
        @(negedge clk_in);
        rdy_in = rdy;
        #1;
    endtask

    task automatic req(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk_in);
        rdy_in     = 1'b1;
        req_valid  = 1'b1;
        req_wr     = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    logic [31:0] wd;
    logic [31:0] wrap_a [4];

    initial begin
        n_chk = 0; n_fail = 0;
        rst_n_in = 1'b0; rdy_in = 1'b1; req_valid = 1'b0; req_wr = 1'b0;
        req_size = 2'd0; req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        mem_din = 8'h00;
        mem[32'h0000_0200] = 8'h78; mem[32'h0000_0201] = 8'h56;
        mem[32'h0000_0202] = 8'h34; mem[32'h0000_0203] = 8'h12;
        mem[32'h0003_0000] = 8'h5A;
        mem[32'h0003_0010] = 8'h01; mem[32'h0003_0011] = 8'h02;
        mem[32'h0003_0012] = 8'h03; mem[32'h0003_0013] = 8'h84;
        wrap_a[0] = 32'hFFFF_FFFE; wrap_a[1] = 32'hFFFF_FFFF;
        wrap_a[2] = 32'h0000_0000; wrap_a[3] = 32'h0000_0001;

        #12;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // Word store 0xDEADBEEF @0x100
        wd = 32'hDEAD_BEEF;
        req(1'b1, 2'd2, 1'b0, 32'h100, wd);
        for (int k = 0; k < 4; k++) begin
            step(1'b1);
            req_valid = 1'b0;
            chk("st_w_wr", {31'd0, mem_wr}, 32'd1);
            chk("st_w_addr", mem_a, 32'h100 + k);
            chk("st_w_dout", {24'd0, mem_dout}, {24'd0, wd[8*k +: 8]});
            chk("st_w_noresp", {31'd0, resp_valid}, 32'd0);
        end
        step(1'b1);
        chk("st_w_resp", {31'd0, resp_valid}, 32'd1);
        chk("st_w_rdata0", resp_rdata, 32'd0);
        chk("st_w_ready", {31'd0, req_ready}, 32'd1);

        // Signed byte load @0x100 -> 0xFFFFFFEF in cycle 3
        req(1'b0, 2'd0, 1'b1, 32'h100, 32'd0);
        step(1'b1); req_valid = 1'b0;
        chk("ld_b_addr", mem_a, 32'h100);
        chk("ld_b_wr", {31'd0, mem_wr}, 32'd0);
        step(1'b1);
        chk("ld_b_c2", {31'd0, resp_valid}, 32'd0);
        step(1'b1);
        chk("ld_b_resp", {31'd0, resp_valid}, 32'd1);
        chk("ld_b_data", resp_rdata, 32'hFFFF_FFEF);

        // Unsigned half load @0x101 -> 0x0000ADBE in cycle 4
        req(1'b0, 2'd1, 1'b0, 32'h101, 32'd0);
        step(1'b1); req_valid = 1'b0;
        step(1'b1);
        chk("ld_h_addr1", mem_a, 32'h102);
        step(1'b1);
        chk("ld_h_c3", {31'd0, resp_valid}, 32'd0);
        step(1'b1);
        chk("ld_h_resp", {31'd0, resp_valid}, 32'd1);
        chk("ld_h_data", resp_rdata, 32'h0000_ADBE);

        // Word load @0x200 with bus withheld in cycle 3 -> response in cycle 8
        req(1'b0, 2'd2, 1'b0, 32'h200, 32'd0);
        step(1'b1); req_valid = 1'b0;
        chk("ld_st_c1", mem_a, 32'h200);
        step(1'b1);
        chk("ld_st_c2", mem_a, 32'h201);
        step(1'b0);
        chk("ld_st_c3wr", {31'd0, mem_wr}, 32'd0);
        step(1'b1);
        chk("ld_st_reissue", mem_a, 32'h201);
        step(1'b1);
        chk("ld_st_c5", mem_a, 32'h202);
        step(1'b1);
        chk("ld_st_c6", mem_a, 32'h203);
        step(1'b1);
        chk("ld_st_c7", {31'd0, resp_valid}, 32'd0);
        step(1'b1);
        chk("ld_st_resp", {31'd0, resp_valid}, 32'd1);
        chk("ld_st_data", resp_rdata, 32'h1234_5678);

        // IO byte load @0x30000: address held two cycles, response cycle 3
        req(1'b0, 2'd0, 1'b0, 32'h3_0000, 32'd0);
        step(1'b1); req_valid = 1'b0;
        chk("io_b_c1", mem_a, 32'h3_0000);
        step(1'b1);
        chk("io_b_c2", mem_a, 32'h3_0000);
        chk("io_b_c2resp", {31'd0, resp_valid}, 32'd0);
        step(1'b1);
        chk("io_b_resp", {31'd0, resp_valid}, 32'd1);
        chk("io_b_data", resp_rdata, 32'h0000_005A);

        // IO word load @0x30010: no pipelining, response cycle 9
        req(1'b0, 2'd2, 1'b0, 32'h3_0010, 32'd0);
        step(1'b1); req_valid = 1'b0;
        step(1'b1);
        chk("io_w_c2", mem_a, 32'h3_0010);
        step(1'b1);
        chk("io_w_c3", mem_a, 32'h3_0011);
        for (int k = 4; k < 9; k++) begin
            step(1'b1);
        end
        chk("io_w_c8", {31'd0, resp_valid}, 32'd0);
        step(1'b1);
        chk("io_w_resp", {31'd0, resp_valid}, 32'd1);
        chk("io_w_data", resp_rdata, 32'h8403_0201);

        // Word store wrapping past 0xFFFFFFFF
        wd = 32'h4433_2211;
        req(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFE, wd);
        for (int k = 0; k < 4; k++) begin
            step(1'b1);
            req_valid = 1'b0;
            chk("wrap_addr", mem_a, wrap_a[k]);
            chk("wrap_dout", {24'd0, mem_dout}, {24'd0, wd[8*k +: 8]});
        end
        step(1'b1);
        chk("wrap_resp", {31'd0, resp_valid}, 32'd1);

        // Back-to-back: second request held and accepted in the response cycle
        req(1'b0, 2'd0, 1'b0, 32'h100, 32'd0);
        step(1'b1);
        req_size = 2'd1; req_signed = 1'b1; req_addr = 32'h102;
        chk("b2b_c1", mem_a, 32'h100);
        step(1'b1);
        chk("b2b_c2", {31'd0, resp_valid}, 32'd0);
        step(1'b1);
        chk("b2b_resp1", {31'd0, resp_valid}, 32'd1);
        chk("b2b_data1", resp_rdata, 32'h0000_00EF);
        chk("b2b_ready", {31'd0, req_ready}, 32'd1);
        step(1'b1); req_valid = 1'b0;
        chk("b2b_c4", mem_a, 32'h102);
        step(1'b1);
        chk("b2b_c5", mem_a, 32'h103);
        step(1'b1);
        chk("b2b_c6", {31'd0, resp_valid}, 32'd0);
        step(1'b1);
        chk("b2b_resp2", {31'd0, resp_valid}, 32'd1);
        chk("b2b_data2", resp_rdata, 32'hFFFF_DEAD);

        // Size code 3 behaves as a word
        req(1'b0, 2'd3, 1'b1, 32'h100, 32'd0);
        step(1'b1); req_valid = 1'b0;
        for (int k = 2; k < 6; k++) begin
            step(1'b1);
        end
        chk("sz3_c5", {31'd0, resp_valid}, 32'd0);
        step(1'b1);
        chk("sz3_resp", {31'd0, resp_valid}, 32'd1);
        chk("sz3_data", resp_rdata, 32'hDEAD_BEEF);

        // Byte store with no grant in cycle 1
        req(1'b1, 2'd0, 1'b0, 32'h300, 32'h0000_00A5);
        step(1'b0); req_valid = 1'b0;
        chk("st_stall_wr0", {31'd0, mem_wr}, 32'd0);
        step(1'b1);
        chk("st_stall_wr1", {31'd0, mem_wr}, 32'd1);
        chk("st_stall_addr", mem_a, 32'h300);
        chk("st_stall_dout", {24'd0, mem_dout}, 32'h0000_00A5);
        step(1'b1);
        chk("st_stall_resp", {31'd0, resp_valid}, 32'd1);
        req(1'b0, 2'd0, 1'b0, 32'h300, 32'd0);
        step(1'b1); req_valid = 1'b0;
        step(1'b1);
        step(1'b1);
        chk("st_stall_rb", resp_rdata, 32'h0000_00A5);

        // Reset in the middle of a word load
        req(1'b0, 2'd2, 1'b0, 32'h200, 32'd0);
        step(1'b1); req_valid = 1'b0;
        step(1'b1);
        @(negedge clk_in);
        rst_n_in = 1'b0;
        #1;
        chk("mid_rst_addr", mem_a, 32'd0);
        chk("mid_rst_wr", {31'd0, mem_wr}, 32'd0);
        chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rst_resp", {31'd0, resp_valid}, 32'd0);
        step(1'b1);
        rst_n_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(1'b1);
            chk("post_rst_noresp", {31'd0, resp_valid}, 32'd0);
        end
        req(1'b0, 2'd0, 1'b1, 32'h3_0013, 32'd0);
        step(1'b1); req_valid = 1'b0;
        step(1'b1);
        step(1'b1);
        chk("post_rst_resp", {31'd0, resp_valid}, 32'd1);
        chk("post_rst_data", resp_rdata, 32'hFFFF_FF84);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- CPU-internal bus master for the byte-wide memory bus: mem_a, mem_dout, mem_wr out; mem_din in; gated by rdy_in.
- Accepts one byte, half-word or word load/store request from the pipeline.
- Serialises the request into consecutive byte accesses, assembles load bytes little-endian, and returns one response.
- RAM and the IO window behind the bus are the responders.

Parameters:
RAM_ADDR_WIDTH, 17, RAM address width; IO window is addr[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]==2'b11

Ports:
clk_in  input  1  system clock, all state on rising edge
rst_n_in  input  1  reset, asynchronous, active-low (one clock; the polarity and synchronicity are fixed)
rdy_in  input  1  bus grant; 0 = bus lent to host debug, no progress
req_valid  input  1  request present
req_ready  output  1  controller can accept (high only in IDLE)
req_wr  input  1  1=store, 0=load
req_size  input  2  0=byte, 1=half, 2=word (3 illegal, treated as word)
req_signed  input  1  sign-extend load result
req_addr  input  32  byte address of lowest byte
req_wdata  input  32  store data, byte k = bits [8k+7:8k]
resp_valid  output  1  one-cycle pulse: request complete
resp_rdata  output  32  extended load data, valid with resp_valid (0 for stores)
mem_din  input  8  read byte from bus, valid the cycle after issue
mem_dout  output  8  write byte
mem_a  output  32  byte address
mem_wr  output  1  1=write this cycle

Behaviour:
- Reset (rst_n_in=0, async): state IDLE; mem_a=0, mem_dout=0, mem_wr=0, req_ready=1, resp_valid=0, resp_rdata=0; any in-flight request discarded, no response.
- States:
  - IDLE: req_ready=1, mem_wr=0, mem_a=0. Accept when req_valid&req_ready at an edge; latch addr/size/signed/wdata; go to RD or WR.
  - WR: byte k (k=0..N-1, N=1/2/4) driven in order, mem_a=addr+k, mem_dout=wdata byte k, mem_wr=1. A byte commits only in a cycle with rdy_in=1; otherwise mem_wr is forced 0 and k holds. After the last commit, return to IDLE with resp_valid=1 next cycle.
  - RD: issue counter i and capture counter c. Byte i issues in a cycle with rdy_in=1, mem_a=addr+i, mem_wr=0. It is captured from mem_din the following cycle, into byte c of the assembly register, only if rdy_in=1 in that capture cycle too.
  - RD pipelining: issue i+1 overlaps capture i.
  - RD stall: if rdy_in=0 in the issue or capture cycle, that byte and any later issued byte are reissued once rdy_in returns (i rewinds to c).
  - RD completion: after byte N-1 is captured, go to IDLE; resp_valid=1 with resp_rdata in the next cycle.
- IO reads (address in IO window):
  - No read pipelining: mem_a held at the same address through the capture cycle, and the next byte is not issued until capture.
  - Pipeline must issue IO loads as byte size; wider sizes are serialised the same way.
- Latency from accept edge (cycle 0), rdy_in=1 throughout:
  - Byte store: byte in cycle 1, resp in 2. Word store: bytes in 1..4, resp in 5.
  - Byte load: issue 1, capture 2, resp 3. Word load (RAM): issues 1..4, captures 2..5, resp 6. Word load (IO): resp 9.
- Response cycle is IDLE: req_ready=1, so a back-to-back request is accepted in the same cycle as resp_valid.
- Extension:
  - Byte: bits[31:8] = signed ? bit7 : 0.
  - Half: bits[31:16] = signed ? bit15 : 0.
  - Word: no extension.
- Address arithmetic is mod 2^32 (0xFFFFFFFF+1 -> 0x00000000). Misaligned addresses are legal; no alignment faults.
- req_* inputs are ignored outside the accept edge; changes mid-operation have no effect.

Decomposition:
- Package mem_ctrl_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state encoding (IDLE/RD/WR), IO window tag 2'b11.
- One sub-module, mem_ctrl_ext: combinational size/sign extension of the assembled 32-bit value.
- FSM, counters and assembly register stay in mem_ctrl.

Test Plan:
- Word store 0xDEADBEEF @0x100, rdy=1 -> bytes EF,BE,AD,DE with mem_a 0x100..0x103 in cycles 1-4, mem_wr=1; resp_valid in cycle 5.
- Load signed byte @0x100 (holding 0xEF) -> resp cycle 3, resp_rdata=0xFFFFFFEF. Unsigned half @0x101 (BE,AD) -> 0x0000ADBE.
- Word load @0x200 with rdy_in=0 during cycle 3 -> byte 1 reissued and captured once, assembled word correct, resp delayed exactly 2 cycles (cycle 8).
- IO byte load @0x30000 -> mem_a=0x30000 for 2 cycles, single capture, resp cycle 3. Word store @0xFFFFFFFE -> mem_a FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- Second request held with req_valid=1 -> accepted in the resp_valid cycle; first response unaffected.
- rst_n_in low mid word load (cycle 3) -> outputs immediately at reset values, no resp_valid; after release the next request completes normally.
